// File: rtl/scalar_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scalar_wb_pkg
// Purpose  : Shared widths and write-back entry type for the scalar WB path.
// Revision : 1.0
// ============================================================================
package scalar_wb_pkg;

  localparam int c_DATA_W = 32;
  localparam int c_ADDR_W = 5;

  typedef struct packed {
    logic [c_ADDR_W-1:0] rd;
    logic [c_DATA_W-1:0] data;
  } wb_entry_t;

endpackage : scalar_wb_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Synchronous FIFO of {rd, data} results with a per-entry rd view.
// Revision : 1.0
// ============================================================================
module wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [ADDR_W-1:0]            i_rd,
  input  logic [DATA_W-1:0]            i_data,
  output logic [ADDR_W-1:0]            o_head_rd,
  output logic [DATA_W-1:0]            o_head_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [DEPTH-1:0]             o_ent_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0] o_ent_rd
);

  localparam int                 c_PTR_W    = $clog2(DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [c_PTR_W:0]   c_CNT_ONE  = (c_PTR_W+1)'(1);
  localparam logic [c_PTR_W:0]   c_FULL_CNT = (c_PTR_W+1)'(DEPTH);

  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_PTR_W:0]   r_count;
  logic [ADDR_W-1:0]  r_mem_rd   [DEPTH];
  logic [DATA_W-1:0]  r_mem_data [DEPTH];
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_count == c_FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + c_PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + c_PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; occupancy is tracked solely by the pointers/count.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem_rd[r_wptr]   <= i_rd;
      r_mem_data[r_wptr] <= i_data;
    end
  end

  assign o_head_rd   = r_mem_rd[r_rptr];
  assign o_head_data = r_mem_data[r_rptr];

  // An entry is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [c_PTR_W-1:0] w_off;
    assign w_off          = c_PTR_W'(i) - r_rptr;
    assign o_ent_valid[i] = ({1'b0, w_off} < r_count);
    assign o_ent_rd[i]    = r_mem_rd[i];
  end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/scalar_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : scalar_writeback_arbiter
// Purpose  : Merges load and buffered ALU results onto the scalar RF write
//            port and flags in-flight writes to the decode read addresses.
//            Macro WB_FORWARD_EN adds forwarding of the output register.
// Revision : 1.0
// ============================================================================
module scalar_writeback_arbiter
  import scalar_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = c_DATA_W,
  parameter int ADDR_W = c_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [ADDR_W-1:0] Rs1,
  input  logic [ADDR_W-1:0] Rs2,
  output logic              rs1_pending,
  output logic              rs2_pending,
  output logic              WriteEn,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] InputData
`ifdef WB_FORWARD_EN
  ,
  output logic              fwd1_valid,
  output logic              fwd2_valid,
  output logic [DATA_W-1:0] fwd1_data,
  output logic [DATA_W-1:0] fwd2_data
`endif
);

  logic                         w_full;
  logic                         w_empty;
  logic                         w_push;
  logic                         w_pop;
  logic [ADDR_W-1:0]            w_head_rd;
  logic [DATA_W-1:0]            w_head_data;
  logic [DEPTH-1:0]             w_ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] w_ent_rd;

  logic              r_wen;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_data;

  assign alu_ready = !w_full;
  assign w_push    = alu_valid && alu_ready;
  // Loads always win; the FIFO drains only in cycles without a load.
  assign w_pop     = !mem_valid && !w_empty;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_rd        (alu_rd),
    .i_data      (alu_data),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_ent_valid (w_ent_valid),
    .o_ent_rd    (w_ent_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen  <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else begin
      r_wen <= mem_valid || !w_empty;
      if (mem_valid) begin
        r_rd   <= mem_rd;
        r_data <= mem_data;
      end else if (!w_empty) begin
        r_rd   <= w_head_rd;
        r_data <= w_head_data;
      end
    end
  end

  assign WriteEn   = r_wen;
  assign rd        = r_rd;
  assign InputData = r_data;

  logic w_fifo_hit1;
  logic w_fifo_hit2;
  logic w_in_hit1;
  logic w_in_hit2;
  logic w_out_hit1;
  logic w_out_hit2;

  always_comb begin
    w_fifo_hit1 = 1'b0;
    w_fifo_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_valid[i] && (w_ent_rd[i] == Rs1)) w_fifo_hit1 = 1'b1;
      if (w_ent_valid[i] && (w_ent_rd[i] == Rs2)) w_fifo_hit2 = 1'b1;
    end
  end

  assign w_in_hit1  = (mem_valid && (mem_rd == Rs1)) || (w_push && (alu_rd == Rs1));
  assign w_in_hit2  = (mem_valid && (mem_rd == Rs2)) || (w_push && (alu_rd == Rs2));
  assign w_out_hit1 = r_wen && (r_rd == Rs1);
  assign w_out_hit2 = r_wen && (r_rd == Rs2);

`ifdef WB_FORWARD_EN
  // The output-register match is served by forwarding instead of a stall.
  assign rs1_pending = w_fifo_hit1 || w_in_hit1;
  assign rs2_pending = w_fifo_hit2 || w_in_hit2;
  assign fwd1_valid  = w_out_hit1;
  assign fwd2_valid  = w_out_hit2;
  assign fwd1_data   = r_data;
  assign fwd2_data   = r_data;
`else
  assign rs1_pending = w_fifo_hit1 || w_in_hit1 || w_out_hit1;
  assign rs2_pending = w_fifo_hit2 || w_in_hit2 || w_out_hit2;
`endif

endmodule : scalar_writeback_arbiter
`default_nettype wire

// File: doc/scalar_writeback_arbiter.md
Name: scalar_writeback_arbiter

Overview:
- Producer side of the scalar register file write port: merges results from the ALU path and the memory-load path into the single write port (WriteEn, rd, InputData).
- Buffers ALU results in a small FIFO while load results take priority.
- Reports pending-write hazards for the decode-stage read addresses (Rs1, Rs2).
- Sits between execute/memory stages and scalar_registers.

Parameters:
- DEPTH, 4, ALU result FIFO entries (power of two, >=2)
- DATA_W, 32, result width; matches register file data
- ADDR_W, 5, register index width (32 registers)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  FIFO can accept; equals !full
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load result offered; always accepted
- mem_rd  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- Rs1, Rs2  in  ADDR_W  decode read addresses for hazard check
- rs1_pending, rs2_pending  out  1  a write to that register is in flight
- WriteEn  out  1  register file write enable (registered)
- rd  out  ADDR_W  register file write address (registered)
- InputData  out  DATA_W  register file write data (registered)

Behaviour:
- Reset (async, rst=1): FIFO pointers and count = 0; WriteEn=0, rd=0, InputData=0. alu_ready reads 1 after reset. Reset mid-operation discards all buffered results, and no write is issued.
- ALU enqueue: alu_valid && alu_ready at a rising edge pushes {alu_rd, alu_data} at the tail.
- Issue selection each cycle:
  - if mem_valid, select the mem result;
  - else if FIFO non-empty, select and pop the head;
  - else no write.
- The selection is registered: WriteEn/rd/InputData update on the next edge.
  - Mem latency: 1 cycle.
  - ALU latency: minimum 2 cycles (enqueue edge, then issue edge).
- WriteEn is high for exactly one cycle per issued result. Back-to-back issues are allowed every cycle.
- Full: alu_ready=0 when count==DEPTH. Push and pop in the same cycle while full is not permitted, because ready is already low.
- Empty with simultaneous push: the entry becomes poppable the following cycle; no bypass.
- Sustained mem_valid starves the FIFO by design. The upstream pipeline guarantees load bursts of at most DEPTH cycles.
- Ordering: ALU results issue in FIFO order. Mem and ALU writes to the same rd issue in arbitration order, and the later write wins in the register file.
- rd=0 is treated like any other register; it is not filtered.
- Pointers wrap modulo DEPTH; count is ADDR range 0..DEPTH.
- Hazard (combinational): rsN_pending=1 if RsN matches any of the following:
  - any valid FIFO entry's rd;
  - mem_rd while mem_valid;
  - alu_rd while alu_valid && alu_ready;
  - rd while WriteEn=1 (write lands this edge, so the register file read is stale until the next cycle).

Optional Feature:
- Macro WB_FORWARD_EN.
- Defined: adds outputs fwd1_valid/fwd2_valid (1 bit) and fwd1_data/fwd2_data (DATA_W). When WriteEn=1 and rd==RsN, fwdN_valid=1 and fwdN_data=InputData, and rsN_pending excludes that output-register match term.
- Undefined: ports absent; pending includes the output-register term as described above.

Decomposition:
- Package scalar_wb_pkg: DATA_W/ADDR_W constants and typedef wb_entry_t {rd, data}.
- One sub-module, wb_fifo: parameterised synchronous FIFO with full/empty/count, plus a per-entry valid/rd view exported for the hazard compare.
- The arbiter, output register and hazard logic stay in the top module.

Test Plan:
- Reset: assert rst mid-stream with 3 entries queued -> WriteEn=0 and alu_ready=1 immediately; no further writes after release.
- ALU-only: push rd=2, data=100 at edge 0 -> WriteEn=1, rd=2, InputData=100 visible after edge 1, for one cycle.
- Priority: same cycle mem_valid (rd=3, 0xAA) and FIFO head (rd=4, 0xBB) -> rd=3 issues first, rd=4 the next cycle.
- Full: hold mem_valid 6 cycles while pushing 5 ALU results -> alu_ready drops after 4; the 5th is accepted after the first pop; all 5 issue in order.
- Hazard: queue rd=7, set Rs1=7, Rs2=8 -> rs1_pending=1, rs2_pending=0 until the cycle after WriteEn for rd=7.
- WB_FORWARD_EN: issue rd=5 data=0x1234 with Rs2=5 -> fwd2_valid=1, fwd2_data=0x1234, rs2_pending=0 that cycle.
